// File: rtl/sdm_alloc_pkg.sv
// Shared types and helpers for the output-port allocators: FSM state encoding,
// default sizes, and one-hot <-> index conversion over an 8-input maximum.
package sdm_alloc_pkg;

    typedef enum logic {ALC_IDLE, ALC_LOCK} alc_state_t;

    localparam int NI_DEF    = 5;
    localparam int CNT_W_DEF = 16;
    localparam int MAX_NI    = 8;

    function automatic logic [MAX_NI-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    function automatic logic [2:0] index(input logic [MAX_NI-1:0] oh);
        index = '0;
        for (int i = 0; i < MAX_NI; i++) begin
            if (oh[i]) index = 3'(i);
        end
    endfunction

endpackage

// File: rtl/out_port_alloc_rr_pick.sv
// rr_pick: combinational rotate-priority picker. Returns the first set request
// found scanning ptr, ptr+1, ... wrapping modulo N.
module rr_pick
    import sdm_alloc_pkg::*;
#(
    parameter int N = NI_DEF,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  sel_oh,
    output logic          any
);

    logic [PW-1:0]     cand;
    logic [PW-1:0]     win;
    logic              found;
    logic [MAX_NI-1:0] oh_full;

    always_comb begin
        cand  = '0;
        win   = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign any     = |req;
    assign oh_full = any ? onehot(3'(win)) : '0;
    assign sel_oh  = oh_full[N-1:0];

endmodule

// File: rtl/out_port_alloc.sv
// Wormhole allocator for one router output port: round-robin grant, locked until the
// granted input's tail flit transfers. Optional stall watchdog under OPA_WATCHDOG_EN.
module out_port_alloc
    import sdm_alloc_pkg::*;
#(
    parameter int NI     = NI_DEF,
    parameter int TO_CYC = 255,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NI-1:0]    req,
    input  logic [NI-1:0]    flit_vld,
    input  logic [NI-1:0]    eof,
    input  logic             out_rdy,
    output logic [NI-1:0]    gnt,
    output logic             busy,
    output logic             fire,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             to_err
);

    localparam int PW = $clog2(NI);

    alc_state_t        state, state_nxt;
    logic [NI-1:0]     gnt_nxt;
    logic [PW-1:0]     ptr, ptr_nxt, ptr_after;
    logic [CNT_W-1:0]  frame_cnt_nxt;
    logic [NI-1:0]     sel_oh;
    logic              any;
    logic [MAX_NI-1:0] gnt_ext;
    logic [2:0]        gidx;
    logic              eof_fire;
    logic              timeout;

    rr_pick #(.N(NI)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .sel_oh (sel_oh),
        .any    (any)
    );

    always_comb begin
        gnt_ext         = '0;
        gnt_ext[NI-1:0] = gnt;
    end

    assign gidx      = index(gnt_ext);
    assign ptr_after = (int'(gidx) == NI - 1) ? '0 : PW'(int'(gidx) + 1);

    assign busy     = (state == ALC_LOCK);
    assign fire     = busy & out_rdy & |(flit_vld & gnt);
    assign eof_fire = fire & |(eof & flit_vld & gnt);

`ifdef OPA_WATCHDOG_EN
    localparam int WD_W = $clog2(TO_CYC + 1);
    logic [WD_W-1:0] wd;

    // Held at zero while idle, so every lock starts with a fresh count.
    always_ff @(posedge clk) begin
        if (rst || !busy || fire) wd <= '0;
        else                      wd <= wd + WD_W'(1);
    end

    assign timeout = busy & ~fire & (wd == WD_W'(TO_CYC));
    assign to_err  = timeout;
`else
    assign timeout = 1'b0;
    assign to_err  = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        ptr_nxt       = ptr;
        frame_cnt_nxt = frame_cnt;
        case (state)
            ALC_IDLE: begin
                if (any) begin
                    state_nxt = ALC_LOCK;
                    gnt_nxt   = sel_oh;
                end
            end
            ALC_LOCK: begin
                // Only the granted input's tail (or a watchdog expiry) unlocks the port.
                if (eof_fire || timeout) begin
                    state_nxt = ALC_IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = ptr_after;
                    if (eof_fire && frame_cnt != '1) frame_cnt_nxt = frame_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ALC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ALC_IDLE;
            gnt       <= '0;
            ptr       <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            ptr       <= ptr_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt));
            assert (busy == |gnt);
            assert (TO_CYC >= 1);
        end
    end
`endif

endmodule

// File: tb/tb_out_port_alloc.sv
// Bench for out_port_alloc: vector table plus hand sequences for saturation and,
// when OPA_WATCHDOG_EN is defined, the stall watchdog.
module tb_out_port_alloc;

    localparam int NI    = 5;
    localparam int CNT_W = 3;
    localparam int TB_TO = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI-1:0]    req, flit_vld, eof, gnt;
    logic             out_rdy, busy, fire, to_err;
    logic [CNT_W-1:0] frame_cnt;

    always #5 clk = ~clk;

    out_port_alloc #(.NI(NI), .TO_CYC(TB_TO), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flit_vld  (flit_vld),
        .eof       (eof),
        .out_rdy   (out_rdy),
        .gnt       (gnt),
        .busy      (busy),
        .fire      (fire),
        .frame_cnt (frame_cnt),
        .to_err    (to_err)
    );

    typedef struct {
        logic       rst;
        logic [4:0] req, vld, eof;
        logic       rdy, chk;
        logic [4:0] gnt;
        logic       busy, fire;
        logic [2:0] cnt;
        logic       terr;
        int         id;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [4:0] vl,
                                input logic [4:0] ef, input logic rd, input logic ck,
                                input logic [4:0] g, input logic b, input logic f,
                                input logic [2:0] c, input logic te, input int id);
        vec_t v;
        v.rst = r;  v.req = rq; v.vld = vl; v.eof = ef; v.rdy = rd; v.chk = ck;
        v.gnt = g;  v.busy = b; v.fire = f; v.cnt = c;  v.terr = te; v.id = id;
        return v;
    endfunction

    task automatic add(input logic r, input logic [4:0] rq, input logic [4:0] vl,
                       input logic [4:0] ef, input logic rd, input logic ck,
                       input logic [4:0] g, input logic b, input logic f, input logic [2:0] c);
        tbl.push_back(mk(r, rq, vl, ef, rd, ck, g, b, f, c, 1'b0, tbl.size()));
    endtask

    task automatic check(input string nm, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h want %0h", nm, id, act, exp);
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rst = v.rst; req = v.req; flit_vld = v.vld; eof = v.eof; out_rdy = v.rdy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        if (e.chk) begin
            check("gnt",       e.id, 32'(gnt),       32'(e.gnt));
            check("busy",      e.id, 32'(busy),      32'(e.busy));
            check("fire",      e.id, 32'(fire),      32'(e.fire));
            check("frame_cnt", e.id, 32'(frame_cnt), 32'(e.cnt));
            check("to_err",    e.id, 32'(to_err),    32'(e.terr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; flit_vld = '0; eof = '0; out_rdy = 1'b0;

        // reset, then single requester on input 2 with a 3-flit frame
        add(1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 0);
        add(1, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b00100, 5'b00100, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b00100, 5'b00100, 5'b00000, 1, 1, 5'b00100, 1, 1, 0);
        add(0, 5'b00100, 5'b00100, 5'b00000, 1, 1, 5'b00100, 1, 1, 0);
        add(0, 5'b00100, 5'b00100, 5'b00100, 1, 1, 5'b00100, 1, 1, 0);
        // ptr now 3: all-request picks input 3
        add(0, 5'b11111, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 1);
        add(0, 5'b11111, 5'b01000, 5'b01000, 1, 1, 5'b01000, 1, 1, 1);
        add(1, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00000, 0, 0, 2);
        // req 10011 rotation with 2-flit frames and one bubble between
        add(0, 5'b10011, 5'b10011, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b10011, 5'b10011, 5'b00000, 1, 1, 5'b00001, 1, 1, 0);
        add(0, 5'b10011, 5'b10011, 5'b10011, 1, 1, 5'b00001, 1, 1, 0);
        add(0, 5'b10011, 5'b10011, 5'b00000, 1, 1, 5'b00000, 0, 0, 1);
        add(0, 5'b10011, 5'b10011, 5'b00000, 1, 1, 5'b00010, 1, 1, 1);
        add(0, 5'b10011, 5'b10011, 5'b10011, 1, 1, 5'b00010, 1, 1, 1);
        add(0, 5'b10011, 5'b10011, 5'b00000, 1, 1, 5'b00000, 0, 0, 2);
        add(0, 5'b10011, 5'b10011, 5'b00000, 1, 1, 5'b10000, 1, 1, 2);
        add(0, 5'b10011, 5'b10011, 5'b10011, 1, 1, 5'b10000, 1, 1, 2);
        add(0, 5'b10011, 5'b10011, 5'b00000, 1, 1, 5'b00000, 0, 0, 3);
        add(0, 5'b10011, 5'b10011, 5'b00000, 1, 1, 5'b00001, 1, 1, 3);
        add(0, 5'b10011, 5'b10011, 5'b10011, 1, 1, 5'b00001, 1, 1, 3);
        // locked on input 1 with eof held but out_rdy low
        add(0, 5'b00010, 5'b00010, 5'b00010, 0, 1, 5'b00000, 0, 0, 4);
        for (int i = 0; i < 10; i++)
            add(0, 5'b00010, 5'b00010, 5'b00010, 0, 1, 5'b00010, 1, 0, 4);
        add(0, 5'b00010, 5'b00010, 5'b00010, 1, 1, 5'b00010, 1, 1, 4);
        // locked on input 2, its request drops; foreign eof ignored
        add(0, 5'b00101, 5'b00100, 5'b00000, 1, 1, 5'b00000, 0, 0, 5);
        add(0, 5'b00101, 5'b00100, 5'b00000, 1, 1, 5'b00100, 1, 1, 5);
        add(0, 5'b00001, 5'b00100, 5'b00000, 1, 1, 5'b00100, 1, 1, 5);
        add(0, 5'b00001, 5'b00101, 5'b00001, 1, 1, 5'b00100, 1, 1, 5);
        add(0, 5'b00001, 5'b00101, 5'b00100, 1, 1, 5'b00100, 1, 1, 5);
        add(0, 5'b00001, 5'b00001, 5'b00000, 1, 1, 5'b00000, 0, 0, 6);
        add(0, 5'b00001, 5'b00001, 5'b00001, 1, 1, 5'b00001, 1, 1, 6);
        // mid-frame reset while locked on input 3
        add(0, 5'b01000, 5'b01000, 5'b00000, 1, 1, 5'b00000, 0, 0, 7);
        add(0, 5'b01000, 5'b01000, 5'b00000, 1, 1, 5'b01000, 1, 1, 7);
        add(1, 5'b01000, 5'b01000, 5'b00000, 0, 1, 5'b01000, 1, 0, 7);
        add(0, 5'b11111, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 0);
        add(0, 5'b11111, 5'b00000, 5'b00000, 1, 1, 5'b00001, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // single requester: re-grant after one bubble, counter saturates at 7
        step(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 1, 5'b00001, 1, 0, 0, 0, 1000));
        for (int k = 0; k < 10; k++) begin
            step(mk(0, 5'b00001, 5'b00001, 5'b00001, 1, 1, 5'b00000, 0, 0,
                    3'(k > 7 ? 7 : k), 0, 1001 + 2 * k));
            step(mk(0, 5'b00001, 5'b00001, 5'b00001, 1, 1, 5'b00001, 1, 1,
                    3'(k > 7 ? 7 : k), 0, 1002 + 2 * k));
        end
        step(mk(0, 5'b00000, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 7, 0, 1100));

`ifdef OPA_WATCHDOG_EN
        // stalled lock on input 0 expires after TB_TO stalled cycles
        step(mk(1, 5'b00000, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0, 0, 0, 0, 2000));
        step(mk(0, 5'b00001, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 0, 0, 2001));
        for (int i = 0; i < TB_TO; i++)
            step(mk(0, 5'b00001, 5'b00000, 5'b00000, 1, 1, 5'b00001, 1, 0, 0, 0, 2002 + i));
        step(mk(0, 5'b00001, 5'b00000, 5'b00000, 1, 1, 5'b00001, 1, 0, 0, 1, 2100));
        step(mk(0, 5'b00011, 5'b00000, 5'b00000, 1, 1, 5'b00000, 0, 0, 0, 0, 2101));
        step(mk(0, 5'b00011, 5'b00000, 5'b00000, 1, 1, 5'b00010, 1, 0, 0, 0, 2102));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
